// File: rtl/minmax_frame_tracker_pkg.sv
// Shared types and default sizes for the min/max frame tracker.
// Latency: none, declarations only.
// Backpressure: not applicable.
package minmax_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // IDLE: no frame open, ACCUM: frame open, HOLD: result waiting for downstream
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/minmax_frame_tracker_if.sv
// Sample-in / result-out bundle for the min/max frame tracker.
// Latency: none, wiring only.
// Backpressure: s_ready gates samples, m_ready releases the held result.
interface minmax_frame_tracker_if
    import minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             clear;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_min;
    logic [WIDTH-1:0] m_max;
    logic [CNT_W-1:0] m_min_idx;
    logic [CNT_W-1:0] m_max_idx;
    logic [CNT_W-1:0] m_count;
    logic             m_ovf;

    // tracker side
    modport slave (
        input  s_valid, s_data, s_last, clear, m_ready,
        output s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx, m_count, m_ovf
    );

    // producer / consumer side
    modport master (
        output s_valid, s_data, s_last, clear, m_ready,
        input  s_ready, m_valid, m_min, m_max, m_min_idx, m_max_idx, m_count, m_ovf
    );

endinterface

// File: rtl/minmax_cmp_update.sv
// Folds one sample into running min/max and their positions; ties keep the earlier index.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module minmax_cmp_update #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    input  logic [CNT_W-1:0] cur_min_idx,
    input  logic [CNT_W-1:0] cur_max_idx,
    input  logic [WIDTH-1:0] sample,
    input  logic [CNT_W-1:0] pos,
    output logic [WIDTH-1:0] upd_min,
    output logic [WIDTH-1:0] upd_max,
    output logic [CNT_W-1:0] upd_min_idx,
    output logic [CNT_W-1:0] upd_max_idx
);

    // strict compares so an equal later sample never moves the index
    always_comb begin
        upd_min     = cur_min;
        upd_max     = cur_max;
        upd_min_idx = cur_min_idx;
        upd_max_idx = cur_max_idx;
        if (sample < cur_min) begin
            upd_min     = sample;
            upd_min_idx = pos;
        end
        if (sample > cur_max) begin
            upd_max     = sample;
            upd_max_idx = pos;
        end
    end

endmodule

// File: rtl/minmax_frame_tracker.sv
// Tracks per-frame min/max values, their positions and sample count; saturating count with sticky overflow.
// Latency: result valid the cycle after the last sample is accepted.
// Backpressure: s_ready low while a result is held; result held stable until m_ready.
module minmax_frame_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    minmax_frame_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    // running accumulators for the open frame
    logic [WIDTH-1:0] acc_min, acc_max;
    logic [CNT_W-1:0] acc_min_idx, acc_max_idx, acc_cnt;
    logic             acc_ovf;

    // accumulator values after folding in the current sample
    logic [WIDTH-1:0] nxt_min, nxt_max;
    logic [CNT_W-1:0] nxt_min_idx, nxt_max_idx, nxt_cnt;
    logic             nxt_ovf;

    logic [WIDTH-1:0] upd_min, upd_max;
    logic [CNT_W-1:0] upd_min_idx, upd_max_idx;

    logic accept, acc_load, out_load;

    assign accept = bus.s_valid & bus.s_ready;

    minmax_cmp_update #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cmp (
        .cur_min     (acc_min),
        .cur_max     (acc_max),
        .cur_min_idx (acc_min_idx),
        .cur_max_idx (acc_max_idx),
        .sample      (bus.s_data),
        .pos         (acc_cnt),
        .upd_min     (upd_min),
        .upd_max     (upd_max),
        .upd_min_idx (upd_min_idx),
        .upd_max_idx (upd_max_idx)
    );

    // first sample of a frame seeds everything; later samples fold in, count saturates and flags overflow
    always_comb begin
        nxt_min     = upd_min;
        nxt_max     = upd_max;
        nxt_min_idx = upd_min_idx;
        nxt_max_idx = upd_max_idx;
        nxt_cnt     = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + 1'b1;
        nxt_ovf     = acc_ovf | (acc_cnt == CNT_MAX);
        if (state == IDLE) begin
            nxt_min     = bus.s_data;
            nxt_max     = bus.s_data;
            nxt_min_idx = '0;
            nxt_max_idx = '0;
            nxt_cnt     = CNT_W'(1);
            nxt_ovf     = 1'b0;
        end
    end

    // state register, reset forces IDLE so m_valid drops immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: clear only aborts an open frame and wins over a same-cycle sample
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = bus.s_last ? HOLD : ACCUM;
            ACCUM: begin
                if (bus.clear)                 state_nxt = IDLE;
                else if (accept && bus.s_last) state_nxt = HOLD;
            end
            HOLD:  if (bus.m_ready)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // handshake outputs and load strobes
    always_comb begin
        bus.s_ready = (state != HOLD);
        bus.m_valid = (state == HOLD);
        acc_load    = accept && !((state == ACCUM) && bus.clear);
        out_load    = acc_load && bus.s_last;
    end

    // accumulators follow every sample that is not cancelled by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_min     <= '0;
            acc_max     <= '0;
            acc_min_idx <= '0;
            acc_max_idx <= '0;
            acc_cnt     <= '0;
            acc_ovf     <= 1'b0;
        end else if (acc_load) begin
            acc_min     <= nxt_min;
            acc_max     <= nxt_max;
            acc_min_idx <= nxt_min_idx;
            acc_max_idx <= nxt_max_idx;
            acc_cnt     <= nxt_cnt;
            acc_ovf     <= nxt_ovf;
        end
    end

    // result registers capture only on the last sample, so they stay put outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_min     <= '0;
            bus.m_max     <= '0;
            bus.m_min_idx <= '0;
            bus.m_max_idx <= '0;
            bus.m_count   <= '0;
            bus.m_ovf     <= 1'b0;
        end else if (out_load) begin
            bus.m_min     <= nxt_min;
            bus.m_max     <= nxt_max;
            bus.m_min_idx <= nxt_min_idx;
            bus.m_max_idx <= nxt_max_idx;
            bus.m_count   <= nxt_cnt;
            bus.m_ovf     <= nxt_ovf;
        end
    end

endmodule

// File: tb/tb_minmax_frame_tracker.sv
// Directed checks of the min/max frame tracker at CNT_W=8 and CNT_W=4.
// Latency: inputs driven 1ns after the rising edge, outputs sampled there too.
// Backpressure: exercised by holding m_ready low with a sample pending.
module tb_minmax_frame_tracker;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    minmax_frame_tracker_if #(.WIDTH(8), .CNT_W(8)) if8 ();
    minmax_frame_tracker_if #(.WIDTH(8), .CNT_W(4)) if4 ();

    minmax_frame_tracker #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    minmax_frame_tracker #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic l);
        if8.s_valid = 1'b1;
        if8.s_data  = d;
        if8.s_last  = l;
        @(posedge clk);
        #1;
        if8.s_valid = 1'b0;
        if8.s_last  = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d, input logic l);
        if4.s_valid = 1'b1;
        if4.s_data  = d;
        if4.s_last  = l;
        @(posedge clk);
        #1;
        if4.s_valid = 1'b0;
        if4.s_last  = 1'b0;
    endtask

    task automatic res8(input string tag, input logic [7:0] mn, input logic [7:0] mni,
                        input logic [7:0] mx, input logic [7:0] mxi, input logic [7:0] cnt);
        check({tag, "_valid"},   32'(if8.m_valid),   32'd1);
        check({tag, "_min"},     32'(if8.m_min),     32'(mn));
        check({tag, "_min_idx"}, 32'(if8.m_min_idx), 32'(mni));
        check({tag, "_max"},     32'(if8.m_max),     32'(mx));
        check({tag, "_max_idx"}, 32'(if8.m_max_idx), 32'(mxi));
        check({tag, "_count"},   32'(if8.m_count),   32'(cnt));
        check({tag, "_ovf"},     32'(if8.m_ovf),     32'd0);
    endtask

    task automatic drain8(input string tag);
        if8.m_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.m_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(if8.m_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(if8.s_ready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if8.s_valid = 1'b0; if8.s_data = '0; if8.s_last = 1'b0; if8.clear = 1'b0; if8.m_ready = 1'b0;
        if4.s_valid = 1'b0; if4.s_data = '0; if4.s_last = 1'b0; if4.clear = 1'b0; if4.m_ready = 1'b0;

        // reset state
        #3;
        check("rst_valid", 32'(if8.m_valid), 32'd0);
        check("rst_ready", 32'(if8.s_ready), 32'd1);
        check("rst_min",   32'(if8.m_min),   32'd0);
        check("rst_max",   32'(if8.m_max),   32'd0);
        check("rst_count", 32'(if8.m_count), 32'd0);
        check("rst_ovf4",  32'(if4.m_ovf),   32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // frame 7,3,9,3,9
        send8(8'd7, 1'b0); send8(8'd3, 1'b0); send8(8'd9, 1'b0); send8(8'd3, 1'b0);
        check("f1_pre_last_valid", 32'(if8.m_valid), 32'd0);
        send8(8'd9, 1'b1);
        res8("f1", 8'd3, 8'd1, 8'd9, 8'd2, 8'd5);
        drain8("f1");

        // single sample frame, then held for 10 cycles with a sample waiting
        send8(8'hA5, 1'b1);
        res8("f2", 8'hA5, 8'd0, 8'hA5, 8'd0, 8'd1);
        if8.s_valid = 1'b1; if8.s_data = 8'h00; if8.s_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 32'(if8.s_ready), 32'd0);
            check("hold_valid", 32'(if8.m_valid), 32'd1);
            check("hold_min",   32'(if8.m_min),   32'hA5);
            check("hold_count", 32'(if8.m_count), 32'd1);
        end
        drain8("f2");
        // the waiting sample goes in only on the cycle after the handshake
        @(posedge clk);
        #1;
        if8.s_valid = 1'b0; if8.s_last = 1'b0;
        res8("f3", 8'h00, 8'd0, 8'h00, 8'd0, 8'd1);
        drain8("f3");

        // clear alongside the third sample, then frame 5,1
        send8(8'd4, 1'b0); send8(8'd8, 1'b0);
        if8.clear = 1'b1;
        send8(8'd2, 1'b0);
        if8.clear = 1'b0;
        check("clr_valid", 32'(if8.m_valid), 32'd0);
        send8(8'd5, 1'b0); send8(8'd1, 1'b1);
        res8("f4", 8'd1, 8'd1, 8'd5, 8'd0, 8'd2);
        // clear while a result is pending leaves it intact
        if8.clear = 1'b1;
        @(posedge clk);
        #1;
        if8.clear = 1'b0;
        check("clr_hold_valid", 32'(if8.m_valid), 32'd1);
        check("clr_hold_count", 32'(if8.m_count), 32'd2);
        drain8("f4");

        // ties keep the earliest position
        send8(8'd5, 1'b0); send8(8'd5, 1'b0); send8(8'd2, 1'b0);
        send8(8'd8, 1'b0); send8(8'd2, 1'b0); send8(8'd8, 1'b1);
        res8("tie", 8'd2, 8'd2, 8'd8, 8'd3, 8'd6);
        drain8("tie");

        // reset mid-frame
        send8(8'd3, 1'b0); send8(8'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(if8.m_valid), 32'd0);
        check("rst_mid_count", 32'(if8.m_count), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send8(8'd10, 1'b0); send8(8'd20, 1'b1);
        res8("f5", 8'd10, 8'd0, 8'd20, 8'd1, 8'd2);
        // reset while holding: valid falls without any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 32'(if8.m_valid), 32'd0);
        check("rst_hold_max",   32'(if8.m_max),   32'd0);
        check("rst_hold_ready", 32'(if8.s_ready), 32'd1);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(if8.m_valid), 32'd0);
        send8(8'd9, 1'b0); send8(8'd4, 1'b0); send8(8'd6, 1'b1);
        res8("f6", 8'd4, 8'd1, 8'd9, 8'd0, 8'd3);
        drain8("f6");

        // CNT_W=4: 20 rising samples 16..35 with 0xFF at position 17
        for (int i = 0; i < 20; i++) begin
            send4((i == 17) ? 8'hFF : 8'(i + 16), (i == 19));
        end
        check("ovf_valid",   32'(if4.m_valid),   32'd1);
        check("ovf_count",   32'(if4.m_count),   32'd15);
        check("ovf_flag",    32'(if4.m_ovf),     32'd1);
        check("ovf_max",     32'(if4.m_max),     32'hFF);
        check("ovf_max_idx", 32'(if4.m_max_idx), 32'd15);
        check("ovf_min",     32'(if4.m_min),     32'd16);
        check("ovf_min_idx", 32'(if4.m_min_idx), 32'd0);
        if4.m_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.m_ready = 1'b0;
        // overflow does not carry into the next frame
        send4(8'd7, 1'b1);
        check("ovf_next_flag",  32'(if4.m_ovf),   32'd0);
        check("ovf_next_count", 32'(if4.m_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minmax_frame_tracker.md
MINMAX_FRAME_TRACKER -- requirements
Module: minmax_frame_tracker

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits, unsigned.
REQ-002 Parameter CNT_W, default 8: width of the sample counter and index fields.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  block accepts a sample this cycle.
REQ-007 s_data  input  WIDTH  sample value.
REQ-008 s_last  input  1  marks the final sample of a frame.
REQ-009 clear  input  1  synchronous abort of the partial frame.
REQ-010 m_valid  output  1  frame result valid.
REQ-011 m_ready  input  1  downstream accepts the result.
REQ-012 m_min, m_max  output  WIDTH each  frame minimum and maximum.
REQ-013 m_min_idx, m_max_idx  output  CNT_W each  zero-based sample position of the min and max.
REQ-014 m_count  output  CNT_W  number of samples in the frame.
REQ-015 m_ovf  output  1  frame exceeded 2^CNT_W-1 samples.

Function
REQ-016 A sample is accepted when s_valid and s_ready are both high on a rising edge.
REQ-017 The FSM has three states: IDLE (no frame open), ACCUM (frame open) and HOLD (result pending).
REQ-018 In IDLE and ACCUM, s_ready is 1; in HOLD, s_ready is 0.
REQ-019 IDLE -> ACCUM on an accepted sample with s_last=0; the sample seeds min/max, both indices are 0 and count is 1.
REQ-020 IDLE -> HOLD on an accepted sample with s_last=1 (single-sample frame: min=max=s_data, indices 0, count 1).
REQ-021 In ACCUM, each accepted sample updates min if s_data < min and max if s_data > max; ties keep the earlier index.
REQ-022 The index of an updating sample equals the count value before that sample's increment.
REQ-023 ACCUM -> HOLD on an accepted sample with s_last=1, with that sample included in the result.
REQ-024 In HOLD, m_valid is 1 and the m_* outputs are stable until handshake; latency is m_valid high on the cycle after the last sample is accepted.
REQ-025 HOLD -> IDLE when m_valid and m_ready are both high; there is no bypass path, so the next sample is accepted no earlier than the following cycle.
REQ-026 Count saturates at 2^CNT_W-1; further samples set the sticky m_ovf flag, still update min/max values, and keep the index fields at the saturated value.
REQ-027 clear in ACCUM returns to IDLE and discards the partial frame; clear has priority over a same-cycle accepted sample.
REQ-028 clear in IDLE or HOLD has no effect; a pending result is never dropped.
REQ-029 The m_* data outputs hold their last values outside HOLD; only m_valid is qualifying.

Reset
REQ-030 Asserting rst_n low forces IDLE immediately and clears m_valid, m_ovf, count, m_min, m_max and both indices to 0; s_ready reads 1.
REQ-031 Reset asserted mid-frame or during HOLD discards all frame state, with no partial result emitted.
REQ-032 Reset deassertion is synchronised externally; the first acceptance occurs no earlier than the first rising edge after release.

Structure
REQ-033 Shared package minmax_pkg holds the FSM state enum (IDLE, ACCUM, HOLD) and the default WIDTH/CNT_W constants.
REQ-034 One sub-module, minmax_cmp_update, is combinational; it takes the current min/max, their indices, the sample and its position, and returns the updated min/max and indices.

Verification
REQ-035 Frame 7,3,9,3,9(last) -> m_min=3, m_min_idx=1, m_max=9, m_max_idx=2, m_count=5, m_ovf=0, m_valid high one cycle after the last beat.
REQ-036 Single sample 0xA5 with s_last=1 from IDLE -> m_min=m_max=0xA5, both indices 0, m_count=1.
REQ-037 m_ready held low for 10 cycles during HOLD -> s_ready=0 and outputs stable throughout; one cycle after handshake, s_ready=1.
REQ-038 CNT_W=4, 20-sample frame with max 0xFF at position 17 -> m_count=15, m_ovf=1, m_max=0xFF, m_max_idx=15.
REQ-039 clear asserted together with the 3rd accepted sample, then frame 5,1(last) -> result m_min=1, m_max=5, m_count=2.
REQ-040 rst_n pulsed low mid-frame and again in HOLD -> m_valid drops asynchronously, no result is emitted, and the next frame's result is correct.
